spart_rx_fifo: RTL and testbench

Receive-side byte buffer directly downstream of the SPART receiver. It captures each byte the receiver delivers on its single-cycle ready pulse and holds it in a circular FIFO until the image-processing host logic pops it. It also generates a level/timeout/overrun interrupt, so the host can drain bursts of pixel bytes without polling each one.

---
 rtl/spart_rx_fifo.sv | 101 ++++++++++
 tb/tb_spart_rx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: receive-side byte FIFO behind the SPART receiver.
// Captures each rx_valid byte into a circular buffer with first-word
// fall-through read-out, and raises an interrupt on fill level, idle
// timeout with data pending, or a dropped byte (sticky overrun).
module spart_rx_fifo #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int THRESH  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rd_en,
    input  logic          clr_ovr,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    output logic          timeout,
    output logic          irq
);

    localparam int          IW       = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] DEPTH_C  = DEPTH[AW:0];
    localparam logic [AW:0] THRESH_C = THRESH[AW:0];
    localparam logic [IW-1:0] TO_C   = TIMEOUT[IW-1:0];

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovr_q, ovr_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          irq_q, irq_d;

    logic push, pop, drop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign count   = count_q;
    assign overrun = ovr_q;
    assign timeout = (idle_q == TO_C);
    assign irq     = irq_q;
    // Head entry is only meaningful while something is stored.
    assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot the incoming byte needs.
    assign pop  = rd_en & ~empty;
    assign push = rx_valid & (~full | pop);
    assign drop = rx_valid & ~push;

    // Next-state for pointers, fill count, overrun, idle timer and irq.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovr_d    = ovr_q;
        idle_d   = idle_q;
        irq_d    = (count_q >= THRESH_C) | timeout | ovr_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push & ~pop)      count_d = count_q + 1'b1;
        else if (pop & ~push) count_d = count_q - 1'b1;

        // Set beats clear when both land in the same cycle.
        if (drop)         ovr_d = 1'b1;
        else if (clr_ovr) ovr_d = 1'b0;

        if (push | pop | empty) idle_d = '0;
        else if (idle_q != TO_C) idle_d = idle_q + 1'b1;
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            idle_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            idle_q   <= idle_d;
            irq_q    <= irq_d;
        end
    end

    // Storage array; contents are never read while empty so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Bench for spart_rx_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_spart_rx_fifo;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int THRESH  = 8;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_ovr = 1'b0;
    logic [7:0]  rd_data;
    logic        empty, full, overrun, timeout, irq;
    logic [AW:0] count;

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    spart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .THRESH(THRESH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_en(rd_en), .clr_ovr(clr_ovr), .rd_data(rd_data), .empty(empty),
        .full(full), .count(count), .overrun(overrun), .timeout(timeout),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, idle time as a plain count.
    logic [7:0] q_m[$];
    bit         ovr_m;
    int         idle_m;
    bit         irq_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_m.delete();
            ovr_m  = 1'b0;
            idle_m = 0;
            irq_m  = 1'b0;
        end else begin
            bit p_pop, p_push;
            p_pop  = rd_en && (q_m.size() > 0);
            p_push = rx_valid && ((q_m.size() < DEPTH) || p_pop);
            irq_m  = (q_m.size() >= THRESH) || (idle_m == TIMEOUT) || ovr_m;
            if (p_push || p_pop || q_m.size() == 0) idle_m = 0;
            else if (idle_m < TIMEOUT) idle_m = idle_m + 1;
            if (rx_valid && !p_push) ovr_m = 1'b1;
            else if (clr_ovr) ovr_m = 1'b0;
            if (p_pop) void'(q_m.pop_front());
            if (p_push) q_m.push_back(rx_data);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_count", 32'(count), 32'(q_m.size()));
            chk("m_empty", 32'(empty), 32'(q_m.size() == 0));
            chk("m_full", 32'(full), 32'(q_m.size() == DEPTH));
            chk("m_rd_data", 32'(rd_data), (q_m.size() > 0) ? 32'(q_m[0]) : 32'h0);
            chk("m_overrun", 32'(overrun), 32'(ovr_m));
            chk("m_timeout", 32'(timeout), 32'(idle_m == TIMEOUT));
            chk("m_irq", 32'(irq), 32'(irq_m));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        tick();
        chk_en = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_irq", 32'(irq), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Three spaced pushes, then in-order pops.
        push(8'hA1); idle(15);
        push(8'hB2); idle(15);
        push(8'hC3);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_head", 32'(rd_data), 32'hA1);
        pop_chk("t1_pop0", 8'hA1);
        pop_chk("t1_pop1", 8'hB2);
        pop_chk("t1_pop2", 8'hC3);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_rd_zero", 32'(rd_data), 32'h00);

        // Fill, overflow, drain, clear overrun.
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            if (i == 8) chk("t2_irq_lag", 32'(irq), 32'd0);
            if (i == 9) chk("t2_irq_on", 32'(irq), 32'd1);
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count", 32'(count), 32'd16);
        chk("t2_irq", 32'(irq), 32'd1);
        push(8'h55);
        chk("t2_overrun", 32'(overrun), 32'd1);
        chk("t2_count_hold", 32'(count), 32'd16);
        for (int i = 1; i <= 16; i++) pop_chk("t2_pop", 8'(i));
        chk("t2_drained", 32'(empty), 32'd1);
        chk("t2_ovr_sticky", 32'(overrun), 32'd1);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        chk("t2_ovr_clr", 32'(overrun), 32'd0);
        tick();

        // Simultaneous push and pop while full.
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        rx_valid = 1'b1; rd_en = 1'b1; rx_data = 8'hEE;
        tick();
        rx_valid = 1'b0; rd_en = 1'b0;
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_no_ovr", 32'(overrun), 32'd0);
        for (int i = 1; i < 16; i++) pop_chk("t3_pop", 8'h20 + 8'(i));
        pop_chk("t3_last", 8'hEE);
        chk("t3_empty", 32'(empty), 32'd1);

        // Simultaneous push and pop while empty.
        rx_valid = 1'b1; rd_en = 1'b1; rx_data = 8'h3C;
        tick();
        rx_valid = 1'b0; rd_en = 1'b0;
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_head", 32'(rd_data), 32'h3C);
        pop_chk("t4_pop", 8'h3C);
        idle(3);

        // Idle timeout after a single push.
        push(8'h9A);
        idle(TIMEOUT - 1);
        chk("t5_to_before", 32'(timeout), 32'd0);
        tick();
        chk("t5_to_set", 32'(timeout), 32'd1);
        chk("t5_irq_lag", 32'(irq), 32'd0);
        tick();
        chk("t5_irq_set", 32'(irq), 32'd1);
        pop_chk("t5_pop", 8'h9A);
        chk("t5_to_clr", 32'(timeout), 32'd0);
        chk("t5_irq_hold", 32'(irq), 32'd1);
        tick();
        chk("t5_irq_clr", 32'(irq), 32'd0);

        // Reset in the middle of traffic, then recover.
        for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
        pop_chk("t6_pop0", 8'h61);
        pop_chk("t6_pop1", 8'h62);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_ovr", 32'(overrun), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        push(8'h77);
        chk("t6_head", 32'(rd_data), 32'h77);
        chk("t6_count", 32'(count), 32'd1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errs++;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $fatal(1, "watchdog");
    end
endmodule
